// File: rtl/clock_pkg.sv
//------------------------------------------------------------------------------
// Module   : clock_pkg
// Brief    : BCD digit types, time limits and digit helpers for the timekeeper.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  localparam bcd2_t SEC_MAX = 8'h59;
  localparam bcd2_t MIN_MAX = 8'h59;
  localparam bcd2_t HR_MAX  = 8'h23;
  localparam bcd2_t HR_NOON = 8'h12;

  typedef enum logic [1:0] {
    BTN_IDLE   = 2'd0,
    BTN_HOLD   = 2'd1,
    BTN_REPEAT = 2'd2
  } btn_state_e;

  function automatic bcd2_t bcd_inc_wrap(input bcd2_t v, input bcd2_t max_v);
    bcd2_t r;
    if (v == max_v) begin
      r = '0;
    end else if (v.ones == 4'd9) begin
      r = {4'(v.tens + 4'd1), 4'd0};
    end else begin
      r = {v.tens, 4'(v.ones + 4'd1)};
    end
    return r;
  endfunction

  // 00 shows as 12, 13..23 fold down by twelve; everything else passes through.
  function automatic bcd2_t hr_to_12h(input bcd2_t h);
    bcd2_t r;
    r = h;
    if (h == 8'h00) begin
      r = HR_NOON;
    end else if (h.tens == 4'd1 && h.ones > 4'd2) begin
      r = {4'd0, 4'(h.ones - 4'd2)};
    end else if (h.tens == 4'd2) begin
      if (h.ones < 4'd2) r = {4'd0, 4'(h.ones + 4'd8)};
      else               r = {4'd1, 4'(h.ones - 4'd2)};
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/button_repeat.sv
//------------------------------------------------------------------------------
// Module   : button_repeat
// Brief    : Button synchroniser, rising-edge detect and hold/auto-repeat pulse.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module button_repeat
  import clock_pkg::*;
#(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 20_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic inc_o
);

  localparam int CW = $clog2(HOLD_CYC + REPEAT_CYC + 1);

  logic [2:0]  sync_q;
  btn_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        inc_q, inc_d;
  logic        w_level;
  logic        w_rise;

  assign w_level = sync_q[1];
  assign w_rise  = sync_q[1] & ~sync_q[2];

  // Synchroniser resets high so a button still held through reset is not seen
  // as a fresh press; it must be released first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q  <= 3'b111;
      state_q <= BTN_IDLE;
      cnt_q   <= '0;
      inc_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[1:0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      inc_q   <= inc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    inc_d   = 1'b0;
    if (!w_level) begin
      state_d = BTN_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        BTN_IDLE: begin
          if (w_rise) begin
            state_d = BTN_HOLD;
            cnt_d   = CW'(1);
            inc_d   = 1'b1;
          end
        end
        BTN_HOLD: begin
          if (cnt_q == CW'(HOLD_CYC)) begin
            state_d = BTN_REPEAT;
            cnt_d   = CW'(1);
            inc_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        BTN_REPEAT: begin
          if (cnt_q == CW'(REPEAT_CYC)) begin
            cnt_d = CW'(1);
            inc_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = BTN_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign inc_o = inc_q;

endmodule

`default_nettype wire

// File: rtl/clock_timekeeper.sv
//------------------------------------------------------------------------------
// Module   : clock_timekeeper
// Brief    : 1 Hz prescaler, BCD time/alarm registers, 12h display and alarm latch.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module clock_timekeeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 20_000_000
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic       tick_hr,
  input  logic       tick_min,
  input  logic       mode_12h,
  input  logic       alarm_set,
  input  logic       alarm_en,
  input  logic       alarm_ack,
  output logic       tick_1Hz,
  output logic [3:0] sec_1s,
  output logic [3:0] sec_10s,
  output logic [3:0] min_1s,
  output logic [3:0] min_10s,
  output logic [3:0] hr_1s,
  output logic [3:0] hr_10s,
  output logic       pm,
  output logic       alarm
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [PW-1:0] presc_q, presc_d;
  bcd2_t sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  bcd2_t al_min_q, al_min_d, al_hr_q, al_hr_d;
  bcd2_t dsec_q, dsec_d, dmin_q, dmin_d, dhr_q, dhr_d;
  logic  tick_q, tick_d, pm_q, pm_d, alarm_q, alarm_d;

  logic  w_inc_hr, w_inc_min, w_term, w_adv;
  bcd2_t w_src_hr, w_src_min;

  button_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_btn_hr (
    .clk_i (clk_100MHz),
    .rst_i (reset),
    .btn_i (tick_hr),
    .inc_o (w_inc_hr)
  );

  button_repeat #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_btn_min (
    .clk_i (clk_100MHz),
    .rst_i (reset),
    .btn_i (tick_min),
    .inc_o (w_inc_min)
  );

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      presc_q  <= '0;
      sec_q    <= '0;
      min_q    <= '0;
      hr_q     <= '0;
      al_min_q <= '0;
      al_hr_q  <= '0;
      dsec_q   <= '0;
      dmin_q   <= '0;
      dhr_q    <= '0;
      tick_q   <= 1'b0;
      pm_q     <= 1'b0;
      alarm_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      min_q    <= min_d;
      hr_q     <= hr_d;
      al_min_q <= al_min_d;
      al_hr_q  <= al_hr_d;
      dsec_q   <= dsec_d;
      dmin_q   <= dmin_d;
      dhr_q    <= dhr_d;
      tick_q   <= tick_d;
      pm_q     <= pm_d;
      alarm_q  <= alarm_d;
    end
  end

  // A button increment in the terminal-count cycle swallows that second.
  assign w_term = (presc_q == PW'(CLK_HZ - 1));
  assign w_adv  = w_term & ~(w_inc_hr | w_inc_min);

  always_comb begin
    presc_d  = w_term ? '0 : presc_q + PW'(1);
    sec_d    = sec_q;
    min_d    = min_q;
    hr_d     = hr_q;
    al_min_d = al_min_q;
    al_hr_d  = al_hr_q;
    tick_d   = w_adv;

    if (alarm_set) begin
      if (w_inc_hr)  al_hr_d  = bcd_inc_wrap(al_hr_q, HR_MAX);
      if (w_inc_min) al_min_d = bcd_inc_wrap(al_min_q, MIN_MAX);
    end else begin
      if (w_inc_hr) hr_d = bcd_inc_wrap(hr_q, HR_MAX);
      if (w_inc_min) begin
        min_d   = bcd_inc_wrap(min_q, MIN_MAX);
        sec_d   = '0;
        presc_d = '0;
      end
    end

    if (w_adv) begin
      sec_d = bcd_inc_wrap(sec_q, SEC_MAX);
      if (sec_q == SEC_MAX) begin
        min_d = bcd_inc_wrap(min_q, MIN_MAX);
        if (min_q == MIN_MAX) hr_d = bcd_inc_wrap(hr_q, HR_MAX);
      end
    end
  end

  always_comb begin
    alarm_d = alarm_q;
    if (!alarm_en || alarm_ack) begin
      alarm_d = 1'b0;
    end else if (w_adv && hr_d == al_hr_q && min_d == al_min_q && sec_d == 8'h00) begin
      alarm_d = 1'b1;
    end
  end

  // Display is built from next-state values so it lines up with the registers.
  always_comb begin
    w_src_hr  = alarm_set ? al_hr_d  : hr_d;
    w_src_min = alarm_set ? al_min_d : min_d;
    dsec_d    = alarm_set ? bcd2_t'(8'h00) : sec_d;
    dmin_d    = w_src_min;
    dhr_d     = mode_12h ? hr_to_12h(w_src_hr) : w_src_hr;
    pm_d      = (w_src_hr >= HR_NOON);
  end

  assign tick_1Hz = tick_q;
  assign sec_1s   = dsec_q.ones;
  assign sec_10s  = dsec_q.tens;
  assign min_1s   = dmin_q.ones;
  assign min_10s  = dmin_q.tens;
  assign hr_1s    = dhr_q.ones;
  assign hr_10s   = dhr_q.tens;
  assign pm       = pm_q;
  assign alarm    = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_timekeeper.sv
//------------------------------------------------------------------------------
// Module   : tb_clock_timekeeper
// Brief    : Scoreboard bench for clock_timekeeper against a seconds-of-day model.
// Revision : 1.1
//------------------------------------------------------------------------------
`default_nettype none

module tb_clock_timekeeper;

    localparam int CLK_HZ = 10;
    localparam int HOLD   = 8;
    localparam int REP    = 4;

    logic clk = 1'b0;
    logic rst, b_hr, b_min, mode, aset, aen, aack;
    logic tick_o, pm_o, alarm_o;
    logic [3:0] s1, s10, m1, m10, h1, h10;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    logic [26:0] exp_q[$];

    always #5 clk = ~clk;

    clock_timekeeper #(.CLK_HZ(CLK_HZ), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)) dut (
        .clk_100MHz (clk),
        .reset      (rst),
        .tick_hr    (b_hr),
        .tick_min   (b_min),
        .mode_12h   (mode),
        .alarm_set  (aset),
        .alarm_en   (aen),
        .alarm_ack  (aack),
        .tick_1Hz   (tick_o),
        .sec_1s     (s1),
        .sec_10s    (s10),
        .min_1s     (m1),
        .min_10s    (m10),
        .hr_1s      (h1),
        .hr_10s     (h10),
        .pm         (pm_o),
        .alarm      (alarm_o)
    );

    // Reference state: time as seconds of day, alarm as hour/minute integers.
    int presc, tod, al_h, al_m;
    bit alarm_m;
    bit prev_in[2], armed[2], pipe1[2], pipe2[2];
    int run[2];

    function automatic bit fires(int k);
        return (k == 0) || (k == HOLD) || (k > HOLD && ((k - HOLD) % REP) == 0);
    endfunction

    function automatic logic [7:0] two_dig(int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_step();
        bit lvl, adv, term;
        bit f[2], app[2];
        bit [1:0] btn;
        int h, m, s, sh, sm, ss, dh;
        if (rst) begin
            presc = 0; tod = 0; al_h = 0; al_m = 0; alarm_m = 0;
            for (int b = 0; b < 2; b++) begin
                prev_in[b] = 1; armed[b] = 0; run[b] = -1; pipe1[b] = 0; pipe2[b] = 0;
            end
            exp_q.push_back('0);
            return;
        end
        btn = {b_min, b_hr};
        for (int b = 0; b < 2; b++) begin
            lvl = prev_in[b];
            prev_in[b] = btn[b];
            f[b] = 0;
            if (!lvl) begin
                armed[b] = 1; run[b] = -1;
            end else if (armed[b]) begin
                run[b]++;
                f[b] = fires(run[b]);
            end
            app[b]   = pipe2[b];
            pipe2[b] = pipe1[b];
            pipe1[b] = f[b];
        end
        term  = (presc == CLK_HZ - 1);
        adv   = term && !(app[0] || app[1]);
        presc = term ? 0 : presc + 1;
        if (aset) begin
            if (app[0]) al_h = (al_h + 1) % 24;
            if (app[1]) al_m = (al_m + 1) % 60;
        end else begin
            h = tod / 3600; m = (tod / 60) % 60; s = tod % 60;
            if (app[0]) h = (h + 1) % 24;
            if (app[1]) begin m = (m + 1) % 60; s = 0; presc = 0; end
            tod = h * 3600 + m * 60 + s;
        end
        if (adv) tod = (tod + 1) % 86400;
        if (!aen || aack) alarm_m = 0;
        else if (adv && tod == al_h * 3600 + al_m * 60) alarm_m = 1;
        sh = aset ? al_h : tod / 3600;
        sm = aset ? al_m : (tod / 60) % 60;
        ss = aset ? 0 : tod % 60;
        dh = mode ? ((sh % 12 == 0) ? 12 : sh % 12) : sh;
        exp_q.push_back({adv, alarm_m, (sh >= 12), two_dig(dh), two_dig(sm), two_dig(ss)});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: the DUT presents a fresh registered output every cycle.
    initial begin
        logic [26:0] got, exp;
        forever begin
            @(negedge clk);
            cyc_no++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                got = {tick_o, alarm_o, pm_o, h10, h1, m10, m1, s10, s1};
                n_tests++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL outputs cycle %0d: got tick=%b alarm=%b pm=%b %h:%h:%h, expected tick=%b alarm=%b pm=%b %h:%h:%h",
                             cyc_no, got[26], got[25], got[24], got[23:16], got[15:8], got[7:0],
                             exp[26], exp[25], exp[24], exp[23:16], exp[15:8], exp[7:0]);
                end
            end
        end
    end

    task automatic check(string what, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", what, got, exp);
        end
    endtask

    task automatic wait_tick(int limit);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (tick_o === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL tick_1Hz: no pulse within %0d cycles", limit);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(int which, int hold);
        if (which == 0) b_hr = 1'b1; else b_min = 1'b1;
        cyc(hold);
        b_hr = 1'b0; b_min = 1'b0;
        cyc(3);
    endtask

    task automatic do_reset();
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
    endtask

    initial begin
        rst = 1'b1; b_hr = 0; b_min = 0; mode = 0; aset = 0; aen = 0; aack = 0;
        cyc(3);
        check("reset digits", {8'h0, h10, h1, m10, m1, s10, s1}, 32'h0);
        check("reset pm", pm_o, 1'b0);
        check("reset alarm", alarm_o, 1'b0);
        check("reset tick", tick_o, 1'b0);
        rst = 1'b0;
        cyc(5);
        mode = 1'b1; cyc(5);
        check("12h midnight hours", {h10, h1}, 8'h12);
        check("12h midnight pm", pm_o, 1'b0);
        mode = 1'b0;
        wait_tick(CLK_HZ + 2);

        // Walk up to 23:59:00 and let it roll over midnight.
        repeat (23) press(0, 1);
        repeat (59) press(1, 1);
        mode = 1'b1; cyc(300); mode = 1'b0; cyc(330);

        // Minute presses at scattered prescaler phases, some landing on terminal count.
        for (int i = 0; i < 30; i++) begin
            cyc($urandom_range(0, 12));
            press(1, 1);
        end

        // Long holds, then a reset in the middle of a hold.
        do_reset();
        repeat (5) press(0, 1);
        press(0, 16);
        press(0, 30);
        b_hr = 1'b1; cyc(12); rst = 1'b1; cyc(2); rst = 1'b0; cyc(20);
        check("no increment after reset mid-hold", {h10, h1}, 8'h00);
        b_hr = 1'b0; cyc(3);
        press(0, 1);
        b_hr = 1'b1; b_min = 1'b1; cyc(20); b_hr = 1'b0; b_min = 1'b0; cyc(3);

        // Alarm 07:30 armed, clock set to 07:29:00 and left to run into it.
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            aset = 1'b1;
            repeat (7) press(0, 1);
            repeat (30) press(1, 1);
            aset = 1'b0;
            aen = (pass == 0);
            repeat (7) press(0, 1);
            repeat (29) press(1, 1);
            cyc(620);
            check("alarm after run to 07:30", alarm_o, (pass == 0) ? 1'b1 : 1'b0);
            aack = 1'b1; cyc(1);
            check("alarm cleared by ack", alarm_o, 1'b0);
            aack = 1'b0; cyc(20);
            aen = 1'b0;
        end

        // 13:05 in 12-hour mode, then a peek at the alarm time.
        do_reset();
        repeat (13) press(0, 1);
        repeat (5) press(1, 1);
        mode = 1'b1; cyc(10);
        check("12h 13:05 hours/minutes", {h10, h1, m10, m1}, 16'h0105);
        check("12h 13:05 pm", pm_o, 1'b1);
        aset = 1'b1; cyc(5);
        check("alarm display 12:00:00", {h10, h1, m10, m1, s10, s1}, 24'h120000);
        check("alarm display pm", pm_o, 1'b0);
        aset = 1'b0; cyc(5);
        mode = 1'b0; cyc(5);

        // Random traffic on every input.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0)   b_hr  = ~b_hr;
            if ($urandom_range(0, 9) == 0)   b_min = ~b_min;
            if ($urandom_range(0, 49) == 0)  mode  = ~mode;
            if ($urandom_range(0, 149) == 0) aset  = ~aset;
            if ($urandom_range(0, 99) == 0)  aen   = ~aen;
            aack = ($urandom_range(0, 29) == 0);
            rst  = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0; b_hr = 0; b_min = 0; aack = 0;
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
